// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and default constants for the register-file
// write-port arbiter.
//   wb_entry_t    : one pending register write {ad, wd}
//   RF_A_WIDTH    : default register address width
//   RF_D_WIDTH    : default register data width
//   RF_FIFO_DEPTH : default MDU result buffer depth (power of two, >= 2)
//   RF_STARVE_LIM : default head wait, in cycles, before a stall request
package rf_ctrl_pkg;

   localparam int RF_A_WIDTH    = 5;
   localparam int RF_D_WIDTH    = 32;
   localparam int RF_FIFO_DEPTH = 2;
   localparam int RF_STARVE_LIM = 4;

   typedef struct packed {
      logic [RF_A_WIDTH-1:0] ad;
      logic [RF_D_WIDTH-1:0] wd;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundles every arbiter signal except clk/rst.
//   ALU writeback : alu_we, alu_ad, alu_wd
//   MDU result    : mdu_valid, mdu_ad, mdu_wd, mdu_ready (back-pressure)
//   Scoreboard    : iss_valid, iss_ad, chk_ad1, chk_ad2, chk_busy
//   Pipeline      : wb_stall
//   Register file : rf_we, rf_ad, rf_wd
// Modports: master = pipeline/MDU/register-file side, slave = the arbiter.
interface regfile_wb_arbiter_if
   import rf_ctrl_pkg::*;
#(
   parameter int A_WIDTH = RF_A_WIDTH,
   parameter int D_WIDTH = RF_D_WIDTH
);
   logic               alu_we;
   logic [A_WIDTH-1:0] alu_ad;
   logic [D_WIDTH-1:0] alu_wd;
   logic               mdu_valid;
   logic [A_WIDTH-1:0] mdu_ad;
   logic [D_WIDTH-1:0] mdu_wd;
   logic               mdu_ready;
   logic               iss_valid;
   logic [A_WIDTH-1:0] iss_ad;
   logic [A_WIDTH-1:0] chk_ad1;
   logic [A_WIDTH-1:0] chk_ad2;
   logic               chk_busy;
   logic               wb_stall;
   logic               rf_we;
   logic [A_WIDTH-1:0] rf_ad;
   logic [D_WIDTH-1:0] rf_wd;

   modport master (
      output alu_we, alu_ad, alu_wd, mdu_valid, mdu_ad, mdu_wd,
             iss_valid, iss_ad, chk_ad1, chk_ad2,
      input  mdu_ready, chk_busy, wb_stall, rf_we, rf_ad, rf_wd
   );

   modport slave (
      input  alu_we, alu_ad, alu_wd, mdu_valid, mdu_ad, mdu_wd,
             iss_valid, iss_ad, chk_ad1, chk_ad2,
      output mdu_ready, chk_busy, wb_stall, rf_we, rf_ad, rf_wd
   );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t holding MDU results awaiting a
// free register-file write cycle. Head is presented combinationally.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : enqueue din_i (ignored when full)
//   pop_i     : dequeue head (ignored when empty)
//   din_i     : entry to enqueue
//   dout_o    : current head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy
module wb_fifo
   import rf_ctrl_pkg::*;
#(
   parameter  int DEPTH = RF_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  wb_entry_t        din_i,
   output wb_entry_t        dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between
// the ALU/load writeback stage (absolute priority, never stalled) and the
// MDU, whose results are buffered in wb_fifo and drained into idle cycles.
// A head-age counter requests a pipeline stall when the buffered head has
// waited STARVE_LIM cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_wb_arbiter_if.slave (ALU, MDU, scoreboard, rf ports)
// Optional feature: define REGFILE_WB_SCOREBOARD_EN to build the busy-
// register scoreboard driving chk_busy; otherwise chk_busy is tied to 0 and
// iss_valid/iss_ad are ignored.
module regfile_wb_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int A_WIDTH    = RF_A_WIDTH,
   parameter int D_WIDTH    = RF_D_WIDTH,
   parameter int FIFO_DEPTH = RF_FIFO_DEPTH,
   parameter int STARVE_LIM = RF_STARVE_LIM
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int AGE_W = $clog2(STARVE_LIM + 1);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

   wb_entry_t        push_ent, head;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             alu_win, push, pop;
   logic [AGE_W-1:0] age_q, age_d;

   // A write to x0 is no write at all, so it leaves the port free.
   assign alu_win = bus.alu_we && (bus.alu_ad != '0);
   assign pop     = !rst && !alu_win && !fifo_empty;

   // No pop-through: acceptance depends on occupancy only.
   assign bus.mdu_ready = !rst && !fifo_full;
   // x0 results are acknowledged but never enqueued.
   assign push     = bus.mdu_valid && bus.mdu_ready && (bus.mdu_ad != '0);
   assign push_ent = '{ad: bus.mdu_ad, wd: bus.mdu_wd};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (push_ent),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Port mux. Address/data follow the ALU by default to keep the mux small.
   always_comb begin
      bus.rf_we = 1'b0;
      bus.rf_ad = bus.alu_ad;
      bus.rf_wd = bus.alu_wd;
      if (!rst) begin
         if (alu_win) begin
            bus.rf_we = 1'b1;
         end else if (!fifo_empty) begin
            bus.rf_we = 1'b1;
            bus.rf_ad = head.ad;
            bus.rf_wd = head.wd;
         end
      end
   end

   // Head age: counts blocked cycles, saturating, cleared on pop/empty.
   always_comb begin
      age_d = age_q;
      if (fifo_empty || pop)  age_d = '0;
      else if (age_q < AGE_LIM) age_d = age_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) age_q <= '0;
      else     age_q <= age_d;
   end

   // Registered age only; rst gating keeps the reset value defined.
   assign bus.wb_stall = !rst && (age_q >= AGE_LIM);

`ifdef REGFILE_WB_SCOREBOARD_EN
   localparam int NREG = 2 ** A_WIDTH;

   logic [NREG-1:0] busy_q, busy_d;

   // Clear first so that a same-cycle issue to the popped register wins.
   always_comb begin
      busy_d = busy_q;
      if (pop) busy_d[head.ad] = 1'b0;
      if (bus.iss_valid && (bus.iss_ad != '0)) busy_d[bus.iss_ad] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign bus.chk_busy = busy_q[bus.chk_ad1] | busy_q[bus.chk_ad2];
`else
   logic unused_sb;
   assign unused_sb    = ^{bus.iss_valid, bus.iss_ad, bus.chk_ad1, bus.chk_ad2};
   assign bus.chk_busy = 1'b0;
`endif

   logic unused_cnt;
   assign unused_cnt = ^{fifo_count, D_WIDTH[0]};
endmodule
